// File: rtl/matvec_seq_ctrl.sv
// Sequencer for the K x K matrix-vector datapath: loads matrix/vector words, then issues row-by-row MAC reads.
// Result valid K+1 cycles after a row starts; input stalls while computing, output holds until output_ready.
module matvec_seq_ctrl #(
  parameter int K   = 3,
  parameter int MAW = $clog2(K*K),
  parameter int VAW = $clog2(K)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           input_valid,
  output logic           input_ready,
  input  logic           new_matrix,
  output logic           mat_we,
  output logic [MAW-1:0] mat_waddr,
  output logic           vec_we,
  output logic [VAW-1:0] vec_waddr,
  output logic [MAW-1:0] mat_raddr,
  output logic [VAW-1:0] vec_raddr,
  output logic           mac_clear,
  output logic           mac_en,
  output logic           output_valid,
  input  logic           output_ready,
  output logic [VAW-1:0] out_row
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_MAT,
    LOAD_VEC,
    COMPUTE,
    DRAIN,
    OUT
  } state_t;

  localparam logic [MAW-1:0] MAT_LAST = MAW'(K*K-1);
  localparam logic [VAW-1:0] VEC_LAST = VAW'(K-1);

  state_t         state, state_nxt;
  logic [MAW-1:0] cnt, cnt_nxt;
  logic [MAW-1:0] rptr, rptr_nxt;
  logic [VAW-1:0] row, row_nxt;
  logic [VAW-1:0] col, col_nxt;
  logic           load_state;
  logic           accept;
  logic           mac_en_q, mac_clear_q;

  assign load_state  = (state == IDLE) || (state == LOAD_MAT) || (state == LOAD_VEC);
  assign input_ready = reset && load_state;
  assign accept      = input_valid && input_ready;

  // The load counter doubles as both write addresses; it is 0 whenever idle.
  assign mat_waddr = cnt;
  assign vec_waddr = cnt[VAW-1:0];
  assign mat_raddr = rptr;
  assign vec_raddr = col;
  assign out_row   = row;
  assign mac_en    = mac_en_q;
  assign mac_clear = mac_clear_q;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    rptr_nxt     = rptr;
    row_nxt      = row;
    col_nxt      = col;
    mat_we       = 1'b0;
    vec_we       = 1'b0;
    output_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (new_matrix) begin
            mat_we = 1'b1;
            if (K*K == 1) begin
              state_nxt = LOAD_VEC;
              cnt_nxt   = '0;
            end else begin
              state_nxt = LOAD_MAT;
              cnt_nxt   = MAW'(1);
            end
          end else begin
            vec_we = 1'b1;
            if (K == 1) begin
              state_nxt = COMPUTE;
              cnt_nxt   = '0;
            end else begin
              state_nxt = LOAD_VEC;
              cnt_nxt   = MAW'(1);
            end
          end
        end
      end
      LOAD_MAT: begin
        if (accept) begin
          mat_we = 1'b1;
          if (cnt == MAT_LAST) begin
            state_nxt = LOAD_VEC;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + MAW'(1);
          end
        end
      end
      LOAD_VEC: begin
        if (accept) begin
          vec_we = 1'b1;
          if (cnt[VAW-1:0] == VEC_LAST) begin
            state_nxt = COMPUTE;
            cnt_nxt   = '0;
            rptr_nxt  = '0;
            row_nxt   = '0;
            col_nxt   = '0;
          end else begin
            cnt_nxt = cnt + MAW'(1);
          end
        end
      end
      COMPUTE: begin
        // rptr tracks row*K+col incrementally, so it runs on across rows.
        rptr_nxt = rptr + MAW'(1);
        if (col == VEC_LAST) begin
          state_nxt = DRAIN;
          col_nxt   = '0;
        end else begin
          col_nxt = col + VAW'(1);
        end
      end
      DRAIN: begin
        state_nxt = OUT;
      end
      OUT: begin
        output_valid = 1'b1;
        if (output_ready) begin
          if (row == VEC_LAST) begin
            state_nxt = IDLE;
            row_nxt   = '0;
            rptr_nxt  = '0;
          end else begin
            state_nxt = COMPUTE;
            row_nxt   = row + VAW'(1);
            col_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rptr        <= '0;
      row         <= '0;
      col         <= '0;
      mac_en_q    <= 1'b0;
      mac_clear_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      rptr        <= rptr_nxt;
      row         <= row_nxt;
      col         <= col_nxt;
      // Read data arrives one cycle after the address, so the MAC controls lag by one.
      mac_en_q    <= (state == COMPUTE);
      mac_clear_q <= (state == COMPUTE) && (col == '0);
    end
  end

endmodule

// File: tb/tb_matvec_seq_ctrl.sv
// Self-checking bench for matvec_seq_ctrl against a frame-level timeline model.
module tb_matvec_seq_ctrl;
  localparam int K   = 3;
  localparam int MAW = $clog2(K*K);
  localparam int VAW = $clog2(K);

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           input_valid = 1'b0;
  logic           new_matrix = 1'b0;
  logic           output_ready = 1'b0;
  logic           input_ready, mat_we, vec_we, mac_clear, mac_en, output_valid;
  logic [MAW-1:0] mat_waddr, mat_raddr;
  logic [VAW-1:0] vec_waddr, vec_raddr, out_row;

  int asserts = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  matvec_seq_ctrl #(.K(K), .MAW(MAW), .VAW(VAW)) dut (
    .clk(clk), .reset(reset),
    .input_valid(input_valid), .input_ready(input_ready), .new_matrix(new_matrix),
    .mat_we(mat_we), .mat_waddr(mat_waddr), .vec_we(vec_we), .vec_waddr(vec_waddr),
    .mat_raddr(mat_raddr), .vec_raddr(vec_raddr), .mac_clear(mac_clear), .mac_en(mac_en),
    .output_valid(output_valid), .output_ready(output_ready), .out_row(out_row)
  );

  // One frame: load phase (word index -> memory/address), then K rows each of
  // K read cycles, one drain cycle and an output phase held until output_ready.
  task automatic run_frame(input bit nm, input int vpct, input int rpct,
                           input int hold_row, input int hold_cyc, output int comp_cycles);
    int words, widx, guard, off, held;
    bit exp_mat, exp_vec, hs;
    words = nm ? K*K + K : K;
    widx = 0;
    guard = 0;
    comp_cycles = 0;
    while (widx < words) begin
      @(posedge clk); #1;
      input_valid  = ($urandom_range(99) < vpct);
      new_matrix   = (widx == 0) ? nm : 1'($urandom_range(1));
      output_ready = 1'($urandom_range(1));
      @(negedge clk);
      exp_mat = input_valid && nm && (widx < K*K);
      exp_vec = input_valid && !(nm && (widx < K*K));
      asserts++;
      if ({input_ready, mat_we, vec_we, output_valid, mac_en} !== {1'b1, exp_mat, exp_vec, 2'b00}) begin
        fails++;
        $display("FAIL load_ctrl word %0d: rdy/mwe/vwe/ov/men got %b%b%b%b%b required 1%b%b00",
                 widx, input_ready, mat_we, vec_we, output_valid, mac_en, exp_mat, exp_vec);
      end
      if (input_valid) begin
        asserts++;
        if (exp_mat ? (mat_waddr !== MAW'(widx)) : (vec_waddr !== VAW'(nm ? widx - K*K : widx))) begin
          fails++;
          $display("FAIL load_addr word %0d: mat_waddr %0d vec_waddr %0d, required %s addr %0d",
                   widx, mat_waddr, vec_waddr, exp_mat ? "mat" : "vec", exp_mat ? widx : (nm ? widx - K*K : widx));
        end
        widx++;
      end
      guard++;
      if (guard > 2000) begin
        fails++;
        $display("FAIL load_timeout: %0d of %0d words accepted", widx, words);
        return;
      end
    end
    for (int r = 0; r < K; r++) begin
      off = 0;
      held = 0;
      hs = 1'b0;
      while (!hs) begin
        @(posedge clk); #1;
        input_valid = 1'($urandom_range(1));
        new_matrix  = 1'($urandom_range(1));
        if (r == hold_row && held < hold_cyc) output_ready = 1'b0;
        else output_ready = ($urandom_range(99) < rpct);
        @(negedge clk);
        comp_cycles++;
        asserts++;
        if ({input_ready, mat_we, vec_we} !== 3'b000) begin
          fails++;
          $display("FAIL compute_noload row %0d off %0d: rdy/mwe/vwe got %b%b%b required 000",
                   r, off, input_ready, mat_we, vec_we);
        end
        asserts++;
        if ({mac_en, mac_clear} !== {(off >= 1 && off <= K), (off == 1)}) begin
          fails++;
          $display("FAIL mac_align row %0d off %0d: en/clr got %b%b required %b%b",
                   r, off, mac_en, mac_clear, (off >= 1 && off <= K), (off == 1));
        end
        if (off < K) begin
          asserts++;
          if ({output_valid, mat_raddr, vec_raddr} !== {1'b0, MAW'(r*K + off), VAW'(off)}) begin
            fails++;
            $display("FAIL read_addr row %0d col %0d: ov %b mat_raddr %0d vec_raddr %0d required 0 %0d %0d",
                     r, off, output_valid, mat_raddr, vec_raddr, r*K + off, off);
          end
        end else if (off == K) begin
          asserts++;
          if (output_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain row %0d: output_valid got %b required 0", r, output_valid);
          end
        end else begin
          asserts++;
          if ({output_valid, out_row} !== {1'b1, VAW'(r)}) begin
            fails++;
            $display("FAIL out_hold row %0d: ov %b out_row %0d required 1 %0d", r, output_valid, out_row, r);
          end
          if (output_ready) hs = 1'b1;
          else if (r == hold_row) held++;
        end
        off++;
        guard++;
        if (guard > 4000) begin
          fails++;
          $display("FAIL compute_timeout: row %0d offset %0d", r, off);
          return;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    input_valid = 1'b1;
    new_matrix = 1'b1;
    output_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    asserts++;
    if ({input_ready, mat_we, vec_we, output_valid, mac_en, mac_clear} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: rdy/mwe/vwe/ov/men/clr got %b%b%b%b%b%b required 000000",
               input_ready, mat_we, vec_we, output_valid, mac_en, mac_clear);
    end
    asserts++;
    if ({mat_waddr, vec_waddr, mat_raddr, vec_raddr, out_row} !== '0) begin
      fails++;
      $display("FAIL reset_addr: waddr %0d/%0d raddr %0d/%0d row %0d required all 0",
               mat_waddr, vec_waddr, mat_raddr, vec_raddr, out_row);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    input_valid = 1'b0;
    @(negedge clk);
    asserts++;
    if (input_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_idle: input_ready got %b required 1", input_ready);
    end
  endtask

  task automatic test_matrix_frame();
    int cc;
    run_frame(1'b1, 100, 100, -1, 0, cc);
    asserts++;
    if (cc !== 3*(K+2)) begin
      fails++;
      $display("FAIL matrix_frame_cycles: got %0d required %0d", cc, 3*(K+2));
    end
  endtask

  task automatic test_vector_frame();
    int cc;
    run_frame(1'b0, 100, 100, -1, 0, cc);
    asserts++;
    if (cc !== K*(K+2)) begin
      fails++;
      $display("FAIL vector_frame_cycles: got %0d required %0d", cc, K*(K+2));
    end
  endtask

  task automatic test_backpressure();
    int cc;
    run_frame(1'b0, 100, 100, 1, 10, cc);
    asserts++;
    if (cc !== K*(K+2) + 10) begin
      fails++;
      $display("FAIL backpressure_cycles: got %0d required %0d", cc, K*(K+2) + 10);
    end
  endtask

  task automatic test_input_gaps();
    int cc;
    run_frame(1'b1, 40, 100, -1, 0, cc);
    asserts++;
    if (cc !== K*(K+2)) begin
      fails++;
      $display("FAIL gaps_cycles: got %0d required %0d", cc, K*(K+2));
    end
  endtask

  task automatic test_reset_mid_compute();
    int cc;
    @(posedge clk); #1;
    input_valid = 1'b1;
    new_matrix = 1'b1;
    output_ready = 1'b1;
    repeat (K*K + K) @(posedge clk);
    #1 input_valid = 1'b0;
    repeat (K + 2) @(posedge clk);
    @(negedge clk);
    asserts++;
    if ({mat_raddr, vec_raddr, output_valid} !== {MAW'(K), VAW'(0), 1'b0}) begin
      fails++;
      $display("FAIL row1_start: mat_raddr %0d vec_raddr %0d ov %b required %0d 0 0",
               mat_raddr, vec_raddr, output_valid, K);
    end
    reset = 1'b0;
    #1;
    asserts++;
    if (input_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_forces_ready: input_ready got %b required 0", input_ready);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    asserts++;
    if ({input_ready, mat_we, vec_we, output_valid, mac_en, mac_clear, mat_raddr, vec_raddr, out_row}
        !== {1'b1, 5'b0, MAW'(0), VAW'(0), VAW'(0)}) begin
      fails++;
      $display("FAIL reset_abort: rdy/mwe/vwe/ov/men/clr %b%b%b%b%b%b raddr %0d/%0d row %0d required 100000 0/0 0",
               input_ready, mat_we, vec_we, output_valid, mac_en, mac_clear, mat_raddr, vec_raddr, out_row);
    end
    run_frame(1'b1, 100, 100, -1, 0, cc);
    asserts++;
    if (cc !== K*(K+2)) begin
      fails++;
      $display("FAIL post_reset_cycles: got %0d required %0d", cc, K*(K+2));
    end
  endtask

  task automatic test_random_frames();
    int cc;
    bit nm;
    for (int i = 0; i < 1000; i++) begin
      nm = (i == 0) ? 1'b1 : 1'($urandom_range(1));
      run_frame(nm, $urandom_range(30, 100), $urandom_range(30, 100), -1, 0, cc);
    end
  endtask

  initial begin
    test_reset();
    test_matrix_frame();
    test_vector_frame();
    test_backpressure();
    test_input_gaps();
    test_reset_mid_compute();
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
